// File: rtl/cus19_imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into
// Instr_Width-bit words (3 bytes per word) and writes them at
// auto-incrementing addresses. It holds the CPU while a load is in flight.
module cus19_imem_loader #(
  parameter int PC_Width    = 11,
  parameter int Instr_Width = 19
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   load_start_in,
  input  logic [PC_Width-1:0]    load_base_in,
  input  logic [PC_Width:0]      load_len_in,
  input  logic                   byte_valid_in,
  input  logic [7:0]             byte_data_in,
  output logic                   byte_ready_out,
  output logic                   imem_we_out,
  output logic [PC_Width-1:0]    imem_waddr_out,
  output logic [Instr_Width-1:0] imem_wdata_out,
  output logic                   cpu_hold_out,
  output logic                   load_busy_out,
  output logic                   load_done_out,
  output logic                   load_err_out,
  output logic [PC_Width:0]      word_count_out
);

  // Number of byte-2 bits that land in the word; the rest must be zero.
  localparam int HiBits = Instr_Width - 16;
  localparam logic [PC_Width:0] LenOne = 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t              state;
  logic [PC_Width-1:0] addr_q;
  logic [PC_Width:0]   remain_q;
  logic [1:0]          byte_idx_q;
  logic [15:0]         asm_q;
  logic                hi_err;

  // Byte 2 carries spare upper bits that a well-formed image leaves clear.
  assign hi_err = (byte_data_in >> HiBits) != 8'd0;

  // Load sequencer; every output is a register updated on state transitions.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: every register is reset here, so an aborted load leaves no
      // stale address, byte index or partial word behind.
      state          <= IDLE;
      addr_q         <= '0;
      remain_q       <= '0;
      byte_idx_q     <= '0;
      asm_q          <= '0;
      byte_ready_out <= 1'b0;
      imem_we_out    <= 1'b0;
      imem_waddr_out <= '0;
      imem_wdata_out <= '0;
      cpu_hold_out   <= 1'b0;
      load_busy_out  <= 1'b0;
      load_done_out  <= 1'b0;
      load_err_out   <= 1'b0;
      word_count_out <= '0;
    end else begin
      // NOTE: non-blocking assignments only; every branch sees the
      // pre-edge values of the state registers.
      case (state)
        IDLE: begin
          if (load_start_in) begin
            addr_q         <= load_base_in;
            remain_q       <= load_len_in;
            word_count_out <= '0;
            load_err_out   <= 1'b0;
            byte_idx_q     <= '0;
            load_busy_out  <= 1'b1;
            cpu_hold_out   <= 1'b1;
            if (load_len_in == '0) begin
              state         <= DONE;
              load_done_out <= 1'b1;
            end else begin
              state          <= RECV;
              byte_ready_out <= 1'b1;
            end
          end
        end

        RECV: begin
          if (byte_valid_in) begin
            case (byte_idx_q)
              2'd0: begin
                asm_q[7:0] <= byte_data_in;
                byte_idx_q <= 2'd1;
              end
              2'd1: begin
                asm_q[15:8] <= byte_data_in;
                byte_idx_q  <= 2'd2;
              end
              default: begin
                imem_wdata_out <= {byte_data_in[HiBits-1:0], asm_q};
                imem_waddr_out <= addr_q;
                imem_we_out    <= 1'b1;
                byte_ready_out <= 1'b0;
                byte_idx_q     <= 2'd0;
                if (hi_err) load_err_out <= 1'b1;
                state <= WRITE;
              end
            endcase
          end
        end

        WRITE: begin
          imem_we_out    <= 1'b0;
          addr_q         <= addr_q + 1'b1;
          word_count_out <= word_count_out + 1'b1;
          remain_q       <= remain_q - 1'b1;
          if (remain_q == LenOne) begin
            state         <= DONE;
            load_done_out <= 1'b1;
          end else begin
            state          <= RECV;
            byte_ready_out <= 1'b1;
          end
        end

        default: begin
          load_done_out <= 1'b0;
          cpu_hold_out  <= 1'b0;
          load_busy_out <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cus19_imem_loader.sv
// Randomised self-checking bench for cus19_imem_loader. Expected writes are
// computed from the byte image with plain arithmetic and compared in order.
module tb_cus19_imem_loader;
  localparam int PW = 11;
  localparam int IW = 19;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          load_start_in = 1'b0;
  logic [PW-1:0] load_base_in = '0;
  logic [PW:0]   load_len_in = '0;
  logic          byte_valid_in = 1'b0;
  logic [7:0]    byte_data_in = '0;
  logic          byte_ready_out;
  logic          imem_we_out;
  logic [PW-1:0] imem_waddr_out;
  logic [IW-1:0] imem_wdata_out;
  logic          cpu_hold_out;
  logic          load_busy_out;
  logic          load_done_out;
  logic          load_err_out;
  logic [PW:0]   word_count_out;

  int total = 0;
  int bad   = 0;

  cus19_imem_loader #(.PC_Width(PW), .Instr_Width(IW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .load_start_in  (load_start_in),
    .load_base_in   (load_base_in),
    .load_len_in    (load_len_in),
    .byte_valid_in  (byte_valid_in),
    .byte_data_in   (byte_data_in),
    .byte_ready_out (byte_ready_out),
    .imem_we_out    (imem_we_out),
    .imem_waddr_out (imem_waddr_out),
    .imem_wdata_out (imem_wdata_out),
    .cpu_hold_out   (cpu_hold_out),
    .load_busy_out  (load_busy_out),
    .load_done_out  (load_done_out),
    .load_err_out   (load_err_out),
    .word_count_out (word_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, byte_ready_out, 0);
    check({tag, "_we"},    imem_we_out, 0);
    check({tag, "_waddr"}, imem_waddr_out, 0);
    check({tag, "_wdata"}, imem_wdata_out, 0);
    check({tag, "_hold"},  cpu_hold_out, 0);
    check({tag, "_busy"},  load_busy_out, 0);
    check({tag, "_done"},  load_done_out, 0);
    check({tag, "_err"},   load_err_out, 0);
    check({tag, "_wcnt"},  word_count_out, 0);
  endtask

  // One load: build the image, compute expected writes, stream the bytes
  // and watch the write port cycle by cycle (sampled on falling edges).
  task automatic run_load(input int base, input int len, input int gap,
                          input bit rand_gap, input int err_mode,
                          input bit start_busy, input int abort_at,
                          input logic [7:0] fixed[$]);
    logic [7:0]    bq[$];
    logic [IW-1:0] exp_data[$];
    int            exp_addr[$];
    logic [7:0]    b0, b1, b2;
    bit            exp_err = 0;
    bit            seen_done = 0;
    bit            aborted = 0;
    int            cyc = 0, ptr = 0, nwr = 0, acc = 0, last_we = -10, stall = 0;

    if (fixed.size() > 0) bq = fixed;
    else begin
      for (int i = 0; i < 3 * len; i++) begin
        if (i % 3 == 2)
          bq.push_back((err_mode == 2 && $urandom_range(0, 3) == 0) ?
                       8'($urandom) : 8'($urandom_range(0, 7)));
        else
          bq.push_back(8'($urandom));
      end
    end
    for (int w = 0; w < len; w++) begin
      b0 = bq[3*w]; b1 = bq[3*w+1]; b2 = bq[3*w+2];
      exp_data.push_back({b2[2:0], b1, b0});
      exp_addr.push_back((base + w) % (1 << PW));
      if (b2[7:3] != 5'd0) exp_err = 1;
    end

    @(negedge clk_in);
    load_base_in  = PW'(base);
    load_len_in   = (PW+1)'(len);
    load_start_in = 1'b1;
    @(negedge clk_in);
    load_start_in = 1'b0;

    while (!seen_done && !aborted && cyc < 20000) begin
      check("hold", cpu_hold_out, 1);
      check("busy", load_busy_out, 1);
      if (cyc == 0) check("err_clear", load_err_out, 0);
      if (imem_we_out) begin
        if (nwr < exp_data.size()) begin
          check("waddr", imem_waddr_out, exp_addr[nwr]);
          check("wdata", imem_wdata_out, exp_data[nwr]);
        end else check("extra_we", imem_we_out, 0);
        nwr++;
        last_we = cyc;
      end
      if (load_done_out) begin
        seen_done = 1;
        check("done_lat", cyc, (len == 0) ? 0 : last_we + 1);
      end

      if (abort_at >= 0 && ptr == abort_at) begin
        rst_in = 1'b1;
        #1;
        check_all_zero("abort");
        check("abort_nwr", nwr, abort_at / 3);
        @(negedge clk_in);
        rst_in = 1'b0;
        aborted = 1;
      end else begin
        if (start_busy && cyc == 4) begin
          load_start_in = 1'b1;
          load_base_in  = PW'(base + 'h40);
          load_len_in   = 1;
        end else if (start_busy && cyc == 5) load_start_in = 1'b0;
        if (stall > 0) begin
          byte_valid_in = 1'b0;
          byte_data_in  = 8'($urandom);
          stall--;
        end else begin
          byte_valid_in = 1'b1;
          byte_data_in  = (ptr < bq.size()) ? bq[ptr] : 8'($urandom);
          if (byte_ready_out) begin
            acc++;
            if (ptr < bq.size()) ptr++;
            stall = rand_gap ? $urandom_range(0, 3) : gap;
          end
        end
        @(negedge clk_in);
        cyc++;
      end
    end
    byte_valid_in = 1'b0;

    if (!aborted) begin
      check("done_seen", seen_done, 1);
      check("nwrites", nwr, len);
      check("bytes_taken", acc, 3 * len);
      check("word_count", word_count_out, len);
      check("err", load_err_out, exp_err);
      check("idle_hold", cpu_hold_out, 0);
      check("idle_busy", load_busy_out, 0);
      check("idle_done", load_done_out, 0);
      check("idle_ready", byte_ready_out, 0);
    end
  endtask

  initial begin
    logic [7:0] none[$];
    logic [7:0] fx[$];

    #2 rst_in = 1'b1;
    #2 check_all_zero("reset");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Basic load, back-to-back bytes.
    fx = '{8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h02};
    run_load('h010, 2, 0, 0, 0, 0, -1, fx);
    // Same image with 3-cycle source stalls between bytes.
    run_load('h010, 2, 3, 0, 0, 0, -1, fx);
    // Address wrap plus format error in the first word.
    fx = '{8'h11, 8'h22, 8'hF9, 8'h33, 8'h44, 8'h01};
    run_load('h7FF, 2, 0, 0, 0, 0, -1, fx);
    repeat (3) @(negedge clk_in);
    check("err_sticky", load_err_out, 1);
    // Zero length.
    run_load('h123, 0, 0, 0, 0, 0, -1, none);
    // Start pulse while busy must be ignored.
    run_load('h100, 3, 0, 1, 0, 1, -1, none);
    // Reset after byte 1 of word 3, then a fresh load.
    run_load('h200, 4, 0, 1, 0, 0, 8, none);
    run_load('h055, 3, 0, 1, 0, 0, -1, none);
    // Random loads with random gaps and occasional format errors.
    for (int k = 0; k < 4; k++)
      run_load($urandom_range(0, (1 << PW) - 1), $urandom_range(1, 6), 0, 1, 2, 0, -1, none);
    // Full-depth load writes every location once, wrapping the address.
    run_load('h3A0, 1 << PW, 0, 0, 0, 0, -1, none);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
